// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: load/store unit to request/response memory bus bridge with abort timeout
module dmem_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        valid_DM,
    output logic        err,
    output logic        Stall_DM,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    logic [1:0] state;
    logic [7:0] cnt;
    logic       tmo;
    assign tmo           = cnt >= LIMIT;
    assign bus_req_valid = state == REQ;
    assign valid_DM      = state == DONE;
    assign Stall_DM      = (state == IDLE && cs) || state == REQ || state == WAIT;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            data_rd   <= '0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (cs) begin
                    bus_we    <= wr;
                    bus_be    <= mask;
                    bus_addr  <= addr;
                    bus_wdata <= data_wr;
                    cnt       <= '0;
                    state     <= REQ;
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus_req_ready) begin
                        state <= WAIT;
                    end else if (tmo) begin
                        state   <= DONE;
                        err     <= 1'b1;
                        data_rd <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // a response arriving on the timeout edge still completes normally
                    if (bus_rsp_valid) begin
                        state   <= DONE;
                        err     <= 1'b0;
                        data_rd <= bus_we ? '0 : bus_rdata;
                    end else if (tmo) begin
                        state   <= DONE;
                        err     <= 1'b1;
                        data_rd <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
